// File: rtl/fp_pkg.sv
// fp_pkg: float format constants, status codes and word layout shared by the FPU and its producers
package fp_pkg;
  localparam int EXP_W = 6;
  localparam int FRAC_W = 25;
  localparam int EXP_MAX = 63;
  typedef enum logic [3:0] {
    ST_NONE      = 4'b0000,
    ST_EXACT     = 4'b0001,
    ST_INEXACT   = 4'b0010,
    ST_OVERFLOW  = 4'b0100,
    ST_UNDERFLOW = 4'b1000
  } status_e;
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp_word_t;
endpackage

// File: rtl/lzc32.sv
// lzc32: combinational leading-zero count of a 32-bit word (32 when the word is zero)
module lzc32 (
  input  logic [31:0] i_val,
  output logic [5:0]  o_cnt
);
  always_comb begin
    o_cnt = 6'd32;
    for (int i = 0; i < 32; i++) if (i_val[i]) o_cnt = 6'(31 - i);
  end
endmodule

// File: rtl/fp_int_encoder.sv
// fp_int_encoder: signed 32-bit integer to float converter with start/done handshake
// Define FP_ENC_FAST_NORM_EN to normalise in a single cycle through lzc32 instead of bit-serially.
module fp_int_encoder
  import fp_pkg::*;
#(
  parameter int EXP_BIAS = 31
) (
  input  logic        clock100KHz,
  input  logic        reset,
  input  logic [31:0] int_in,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] data_out,
  output logic [3:0]  status_out
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_NORM  = 3'd2;
  localparam logic [2:0] S_ROUND = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;
  localparam logic [6:0] EXP_INIT = 7'(EXP_BIAS + 31);
  logic [2:0]        r_state;
  logic [31:0]       r_int;
  logic [31:0]       r_mag;
  logic [6:0]        r_exp;
  logic              r_sign;
  logic              r_zero;
  logic              r_inexact;
  logic [FRAC_W-1:0] r_frac;
  logic [31:0]       w_abs;
  logic              w_carry;
  fp_word_t          w_word;
  assign w_abs   = r_int[31] ? -r_int : r_int;
  assign w_carry = r_mag[5] & (&r_mag[30:6]);
  assign w_word  = '{sign: r_sign, exp: r_exp[EXP_W-1:0], frac: r_frac};
`ifdef FP_ENC_FAST_NORM_EN
  logic [5:0] w_lzc;
  lzc32 u_lzc (.i_val(r_mag), .o_cnt(w_lzc));
`endif
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_int      <= '0;
      r_mag      <= '0;
      r_exp      <= '0;
      r_sign     <= 1'b0;
      r_zero     <= 1'b0;
      r_inexact  <= 1'b0;
      r_frac     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      data_out   <= '0;
      status_out <= ST_NONE;
    end else begin
      done <= 1'b0;
      case (r_state)
        // done shares its cycle with IDLE, so a start in that cycle is dropped
        S_IDLE: if (start && !done) begin
          r_int   <= int_in;
          busy    <= 1'b1;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_sign  <= r_int[31];
          r_mag   <= w_abs;
          r_exp   <= EXP_INIT;
          r_zero  <= w_abs == '0;
          r_state <= (w_abs == '0) ? S_OUT : w_abs[31] ? S_ROUND : S_NORM;
        end
`ifdef FP_ENC_FAST_NORM_EN
        S_NORM: begin
          r_mag   <= r_mag << w_lzc;
          r_exp   <= r_exp - {1'b0, w_lzc};
          r_state <= S_ROUND;
        end
`else
        S_NORM: begin
          r_mag   <= r_mag << 1;
          r_exp   <= r_exp - 7'd1;
          r_state <= r_mag[30] ? S_ROUND : S_NORM;
        end
`endif
        S_ROUND: begin
          r_frac    <= r_mag[30:6] + {24'd0, r_mag[5]};
          r_exp     <= r_exp + {6'd0, w_carry};
          r_inexact <= |r_mag[5:0];
          r_state   <= S_OUT;
        end
        S_OUT: begin
          data_out   <= (r_zero || r_exp >= 7'(EXP_MAX) || r_exp == '0 || r_exp[6]) ? '0 : w_word;
          status_out <= r_zero ? ST_EXACT : r_exp >= 7'(EXP_MAX) ? ST_OVERFLOW :
                        (r_exp == '0 || r_exp[6]) ? ST_UNDERFLOW : r_inexact ? ST_INEXACT : ST_EXACT;
          done       <= 1'b1;
          busy       <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_int_encoder.sv
// tb_fp_int_encoder: scoreboard bench for fp_int_encoder at biases 31, 40 and 0
module tb_fp_int_encoder;
  typedef struct {
    logic [31:0] data;
    logic [3:0]  st;
    int          lat;
  } exp_t;
  localparam logic [3:0] EXACT = 4'b0001, INEXACT = 4'b0010, OVF = 4'b0100, UNF = 4'b1000;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] int_in = '0;
  logic [2:0]  busy, done;
  logic [31:0] dout [3];
  logic [3:0]  st [3];
  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  always #5 clk = ~clk;
  fp_int_encoder #(.EXP_BIAS(31)) u_dut (.clock100KHz(clk), .reset(rst_n), .int_in(int_in), .start(start),
    .busy(busy[0]), .done(done[0]), .data_out(dout[0]), .status_out(st[0]));
  fp_int_encoder #(.EXP_BIAS(40)) u_ovf (.clock100KHz(clk), .reset(rst_n), .int_in(int_in), .start(start),
    .busy(busy[1]), .done(done[1]), .data_out(dout[1]), .status_out(st[1]));
  fp_int_encoder #(.EXP_BIAS(0)) u_unf (.clock100KHz(clk), .reset(rst_n), .int_in(int_in), .start(start),
    .busy(busy[2]), .done(done[2]), .data_out(dout[2]), .status_out(st[2]));

  // g: cycle index at which a stray start is pulsed while busy; sd: hold start during the done cycle
  task automatic convert(input int d, input logic [31:0] v, input logic [31:0] ed, input logic [3:0] es,
                         input int el, input int g, input bit sd, input string nm);
    exp_t e;
    int   n;
    logic stray;
    @(negedge clk);
    int_in = v;
    start = 1'b1;
    q.push_back('{ed, es, el});
    @(posedge clk);
    #1 start = 1'b0;
    n_tests++;
    if (busy[d] !== 1'b1) begin n_fail++; $display("FAIL %s busy_after_accept got %b want 1", nm, busy[d]); end
    n = 1;
    while (done[d] !== 1'b1 && n < 60) begin
      if (n == g) begin start = 1'b1; int_in = 32'd5; end
      @(posedge clk);
      #1 start = 1'b0;
      n++;
    end
    e = q.pop_front();
    n_tests++;
    if (n !== e.lat) begin n_fail++; $display("FAIL %s latency got %0d want %0d", nm, n, e.lat); end
    n_tests++;
    if (dout[d] !== e.data) begin n_fail++; $display("FAIL %s data got %h want %h", nm, dout[d], e.data); end
    n_tests++;
    if (st[d] !== e.st) begin n_fail++; $display("FAIL %s status got %b want %b", nm, st[d], e.st); end
    n_tests++;
    if (busy[d] !== 1'b0) begin n_fail++; $display("FAIL %s busy_at_done got %b want 0", nm, busy[d]); end
    start = sd;
    stray = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 start = 1'b0;
      stray = stray | done[d] | busy[d];
    end
    n_tests++;
    if (stray !== 1'b0) begin n_fail++; $display("FAIL %s idle_after_done got %b want 0", nm, stray); end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({busy[i], done[i], dout[i], st[i]} !== '0) begin
        n_fail++;
        $display("FAIL reset_state[%0d] got %b/%b/%h/%b want 0/0/0/0", i, busy[i], done[i], dout[i], st[i]);
      end
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_convert();
    convert(0, 32'd1,        32'h3E000000, EXACT,   35, 0, 1'b0, "one");
    convert(0, 32'd100,      32'h4B200000, EXACT,   29, 0, 1'b0, "hundred");
    convert(0, 32'hFFFFFFFF, 32'hBE000000, EXACT,   35, 0, 1'b0, "minus_one");
    convert(0, 32'h7FFFFFFF, 32'h7C000000, INEXACT,  5, 0, 1'b0, "round_carry");
    convert(0, 32'h80000000, 32'hFC000000, EXACT,    4, 0, 1'b0, "int_min");
    convert(0, 32'h7FFFFFC0, 32'h7BFFFFFE, EXACT,    5, 0, 1'b0, "no_round");
    convert(0, 32'h40000001, 32'h7A000000, INEXACT,  5, 0, 1'b0, "sticky_only");
    convert(0, 32'h40000010, 32'h7A000001, INEXACT,  5, 0, 1'b0, "round_up");
  endtask

  task automatic test_zero_and_busy();
    convert(0, 32'd1, 32'h3E000000, EXACT, 35, 10, 1'b0, "start_while_busy");
    convert(0, 32'd0, 32'h00000000, EXACT,  3,  2, 1'b1, "zero");
  endtask

  task automatic test_range();
    convert(1, 32'h40000000, 32'h00000000, OVF, 5,  0, 1'b0, "overflow");
    convert(2, 32'd1,        32'h00000000, UNF, 35, 0, 1'b0, "underflow");
  endtask

  task automatic test_reset_mid();
    logic seen;
    convert(0, 32'd100, 32'h4B200000, EXACT, 29, 0, 1'b0, "pre_abort");
    @(negedge clk);
    int_in = 32'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy[0], done[0], dout[0], st[0]} !== '0) begin
      n_fail++;
      $display("FAIL abort_reset got %b/%b/%h/%b want 0/0/0/0", busy[0], done[0], dout[0], st[0]);
    end
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1 seen = seen | (|done) | (|busy);
    end
    n_tests++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got %b want 0", seen); end
    convert(0, 32'd100, 32'h4B200000, EXACT, 29, 0, 1'b0, "after_abort");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_convert();
    test_zero_and_busy();
    test_range();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
